// File: rtl/popcount_pkg.sv
// Shared types and widths for the popcount sequencer and its datapath.
package popcount_pkg;
  localparam int WORD_W = 64;
  localparam int PCNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/popcount_seq_if.sv
// Word-in / total-out handshake bundle for popcount_seq.
// master: word source and result consumer. slave: the sequencer.
interface popcount_seq_if #(
  parameter int MAX_WORDS = 256
);
  import popcount_pkg::*;
  localparam int LEN_W = $clog2(MAX_WORDS + 1);
  localparam int CNT_W = $clog2(MAX_WORDS * 64 + 1);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  busy, in_ready, out_valid, out_count
  );
  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output busy, in_ready, out_valid, out_count
  );
endinterface

// File: rtl/popcount64.sv
// Purely combinational 64-bit population count.
module popcount64
  import popcount_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [PCNT_W-1:0] cnt
);
  // sum every bit of the word; synthesis builds the adder tree
  always_comb begin
    cnt = '0;
    for (int i = 0; i < WORD_W; i++) cnt = cnt + PCNT_W'(din[i]);
  end
endmodule

// File: rtl/popcount_seq.sv
// Job sequencer: streams up to MAX_WORDS words through popcount64 and
// returns the accumulated bit total on a result handshake.
// Optional macro POPCOUNT_SEQ_PIPE_EN registers the per-word count before the
// accumulator and adds a DRAIN state to absorb the last in-flight count.
module popcount_seq
  import popcount_pkg::*;
#(
  parameter int MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  popcount_seq_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_WORDS + 1);
  localparam int CNT_W = $clog2(MAX_WORDS * 64 + 1);

  state_t             state, nstate;
  logic [LEN_W-1:0]   rem;
  logic [LEN_W-1:0]   len_c;
  logic [CNT_W-1:0]   acc;
  logic [PCNT_W-1:0]  pc;
  logic               xfer;
  logic               last;
  logic               add_en;
  logic [PCNT_W-1:0]  add_val;

  assign len_c = (bus.len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : bus.len;
  assign xfer  = bus.in_valid && (state == ACCUM);
  assign last  = xfer && (rem == LEN_W'(1));

  popcount64 u_pc (.din(bus.in_data), .cnt(pc));

`ifdef POPCOUNT_SEQ_PIPE_EN
  logic [PCNT_W-1:0] pc_q;
  logic              pc_vld;

  // pipe stage: hold the count of the word accepted last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      pc_vld <= 1'b0;
    end else begin
      pc_q   <= pc;
      pc_vld <= xfer;
    end
  end

  assign add_en  = pc_vld;
  assign add_val = pc_q;
`else
  assign add_en  = xfer;
  assign add_val = pc;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // next-state decode; start only matters in IDLE
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (bus.start) nstate = (len_c == '0) ? DONE : ACCUM;
`ifdef POPCOUNT_SEQ_PIPE_EN
      ACCUM: if (last) nstate = DRAIN;
`else
      ACCUM: if (last) nstate = DONE;
`endif
      DRAIN: nstate = DONE;
      DONE:  if (bus.out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // remaining-word counter and accumulator; a new job clears the total
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      acc <= '0;
    end else if (state == IDLE && bus.start) begin
      rem <= len_c;
      acc <= '0;
    end else begin
      if (xfer)   rem <= rem - LEN_W'(1);
      if (add_en) acc <= acc + CNT_W'(add_val);
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.out_count = acc;
endmodule

// File: tb/tb_popcount_seq.sv
// Self-checking bench for popcount_seq: directed table, corner sequences
// and randomized jobs scored against a bit-counting reference model.
module tb_popcount_seq;
  localparam int MW    = 256;
  localparam int LEN_W = $clog2(MW + 1);
  localparam int CNT_W = $clog2(MW * 64 + 1);
`ifdef POPCOUNT_SEQ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    int              jl;
    int              mode;
    logic [3:0][63:0] w;
    int              exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [63:0] wq[$];

  popcount_seq_if #(.MAX_WORDS(MW)) bus ();
  popcount_seq #(.MAX_WORDS(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int ref_pop(input logic [63:0] w);
    int c = 0;
    for (int i = 0; i < 64; i++) if (w[i]) c++;
    return c;
  endfunction

  function automatic int ref_total(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += ref_pop(wq[i]);
    return s;
  endfunction

  // start a job and feed words from wq; leaves the DUT in DONE with result checked
  // mode 0: no gaps, 1: alternating gaps, 2: random gaps
  task automatic feed_job(input int jl, input int mode, input int exp, input string nm);
    int   n, idx, budget;
    logic v, acc;
    n = (jl > MW) ? MW : jl;
    bus.start = 1'b1;
    bus.len   = LEN_W'(jl);
    tick();
    bus.start = 1'b0;
    if (n == 0) begin
      chk({nm, " zero-len out_valid"}, bus.out_valid, 1);
      chk({nm, " zero-len in_ready"}, bus.in_ready, 0);
      chk({nm, " zero-len count"}, bus.out_count, 0);
      return;
    end
    chk({nm, " in_ready after start"}, bus.in_ready, 1);
    idx = 0;
    budget = 0;
    while (idx < n && budget < 4 * n + 20) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = budget[0];
        default: v = ($urandom % 3) != 0;
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? wq[idx] : {$urandom, $urandom};
      acc = v && bus.in_ready;
      tick();
      budget++;
      if (acc) idx++;
    end
    if (idx < n) chk({nm, " words accepted before timeout"}, 64'(idx), 64'(n));
    // offer a junk word during the result latency; it must not be consumed
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    chk({nm, " in_ready dropped"}, bus.in_ready, 0);
    for (int k = 1; k < LAT; k++) begin
      chk({nm, " out_valid early"}, bus.out_valid, 0);
      tick();
    end
    chk({nm, " out_valid latency"}, bus.out_valid, 1);
    chk({nm, " count"}, bus.out_count, 64'(exp));
    bus.in_valid = 1'b0;
  endtask

  task automatic ack(input string nm);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, " out_valid after ack"}, bus.out_valid, 0);
    chk({nm, " busy after ack"}, bus.busy, 0);
  endtask

  vec_t tbl[4];

  initial begin
    int e;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick(); tick(); tick();
    chk("reset busy", bus.busy, 0);
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_count", bus.out_count, 0);
    rst = 1'b0;
    tick();

    tbl[0] = '{jl: 1, mode: 0, exp: 64,
               w: {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};
    tbl[1] = '{jl: 4, mode: 1, exp: 35,
               w: {64'h0F0F_0F0F_0F0F_0F0F, 64'h8000_0000_0000_0001, 64'h1, 64'h0}};
    tbl[2] = '{jl: 0, mode: 0, exp: 0, w: '0};
    tbl[3] = '{jl: 2, mode: 2, exp: 4, w: {64'h0, 64'h0, 64'h3, 64'h3}};

    for (int i = 0; i < 4; i++) begin
      wq.delete();
      for (int j = 0; j < 4; j++) wq.push_back(tbl[i].w[j]);
      feed_job(tbl[i].jl, tbl[i].mode, tbl[i].exp, $sformatf("tbl%0d", i));
      ack($sformatf("tbl%0d", i));
    end

    // full-length and clamped-length jobs of all-ones words
    wq.delete();
    for (int i = 0; i < MW + 8; i++) wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    feed_job(MW, 0, MW * 64, "max");
    ack("max");
    feed_job(MW + 5, 0, MW * 64, "clamp");
    ack("clamp");

    // result held under backpressure; start pulses ignored
    wq.delete();
    wq.push_back({$urandom, $urandom});
    wq.push_back({$urandom, $urandom});
    e = ref_total(2);
    feed_job(2, 0, e, "stall");
    for (int k = 0; k < 10; k++) begin
      bus.start = 1'($urandom % 2);
      bus.len   = LEN_W'(5);
      tick();
      chk("stall out_valid", bus.out_valid, 1);
      chk("stall count", bus.out_count, 64'(e));
    end
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk("start at ack ignored busy", bus.busy, 0);
    chk("start at ack ignored in_ready", bus.in_ready, 0);
    wq.delete();
    wq.push_back(64'h00FF);
    feed_job(1, 0, 8, "after stall");
    ack("after stall");

    // reset mid-job discards it
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back({$urandom, $urandom});
    bus.start = 1'b1;
    bus.len = LEN_W'(8);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = wq[i];
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset out_valid", bus.out_valid, 0);
    chk("mid reset in_ready", bus.in_ready, 0);
    chk("mid reset out_count", bus.out_count, 0);
    wq.delete();
    wq.push_back(64'h3);
    wq.push_back(64'h3);
    feed_job(2, 0, 4, "post reset");
    ack("post reset");

    // randomized jobs against the reference model
    for (int r = 0; r < 25; r++) begin
      int jl;
      jl = $urandom_range(0, 12);
      wq.delete();
      for (int i = 0; i < jl; i++) wq.push_back({$urandom, $urandom});
      feed_job(jl, 2, ref_total(jl), $sformatf("rand%0d", r));
      ack($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
